cr_su_ib_rx: RTL and testbench



---
 rtl/cr_su_ib_rx.sv | 190 +++++++++++++++++++
 tb/tb_cr_su_ib_rx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_su_ib_rx.sv
// Scheduler-update ingress: assembles REC_BEATS x 64-bit stream beats into one record, buffers records in a FIFO.
// Latency: a record shows on rec_valid the cycle after its final-beat handshake; frame_err_stb one cycle after the bad beat.
// Backpressure: su_ib_tready drops only on the final beat of a frame while the record FIFO is full.
module cr_su_ib_rx #(
    parameter int REC_BEATS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    su_ib_tvalid,
    input  logic                    su_ib_tlast,
    input  logic [63:0]             su_ib_tdata,
    output logic                    su_ib_tready,
    output logic                    rec_valid,
    output logic [64*REC_BEATS-1:0] rec_data,
    input  logic                    rec_ready,
    output logic                    frame_err_stb,
    output logic [CNT_W-1:0]        rec_cnt,
    output logic [CNT_W-1:0]        err_cnt
);

    localparam int IDX_W = (REC_BEATS > 1) ? $clog2(REC_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BEATS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ASSM = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t                        state, state_nxt;
    logic [IDX_W-1:0]              beat_idx, beat_idx_nxt;
    logic [REC_BEATS-2:0][63:0]    asm_q;
    logic [REC_BEATS-1:0][63:0]    push_dat;
    logic                          push_vld;
    logic                          err_hit;
    logic                          beat_acc;
    logic                          last_idx;
    logic                          fifo_full;

    assign last_idx = (beat_idx == LAST_IDX);
    assign beat_acc = su_ib_tvalid && su_ib_tready;
    // The final beat bypasses the assembly register and lands straight in the FIFO.
    assign push_dat = {su_ib_tdata, asm_q};

    always_comb begin
        state_nxt    = state;
        beat_idx_nxt = beat_idx;
        push_vld     = 1'b0;
        err_hit      = 1'b0;
        su_ib_tready = 1'b0;
        if (rst_n) begin
            case (state)
                ASSM: begin
                    su_ib_tready = last_idx ? !fifo_full : 1'b1;
                    if (beat_acc) begin
                        if (!last_idx) begin
                            if (su_ib_tlast) begin
                                err_hit      = 1'b1;
                                beat_idx_nxt = '0;
                            end else begin
                                beat_idx_nxt = beat_idx + IDX_ONE;
                            end
                        end else if (su_ib_tlast) begin
                            push_vld     = 1'b1;
                            beat_idx_nxt = '0;
                        end else begin
                            err_hit      = 1'b1;
                            beat_idx_nxt = '0;
                            state_nxt    = DROP;
                        end
                    end
                end
                DROP: begin
                    su_ib_tready = 1'b1;
                    if (beat_acc && su_ib_tlast) begin
                        state_nxt    = ASSM;
                        beat_idx_nxt = '0;
                    end
                end
                default: begin
                    state_nxt    = ASSM;
                    beat_idx_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ASSM;
            beat_idx      <= '0;
            frame_err_stb <= 1'b0;
            rec_cnt       <= '0;
            err_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            beat_idx      <= beat_idx_nxt;
            frame_err_stb <= err_hit;
            if (push_vld && (rec_cnt != CNT_MAX)) begin
                rec_cnt <= rec_cnt + CNT_ONE;
            end
            if (err_hit && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end
    end

    // Payload only; stale slots are always overwritten before the next push.
    always_ff @(posedge clk) begin
        if (beat_acc && (state == ASSM) && !last_idx) begin
            for (int k = 0; k < REC_BEATS - 1; k++) begin
                if (beat_idx == IDX_W'(k)) begin
                    asm_q[k] <= su_ib_tdata;
                end
            end
        end
    end

    cr_su_ib_rx_fifo #(
        .W     (64 * REC_BEATS),
        .DEPTH (FIFO_DEPTH)
    ) u_rec_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (push_vld),
        .wr_dat (push_dat),
        .full   (fifo_full),
        .rd_vld (rec_valid),
        .rd_dat (rec_data),
        .rd_rdy (rec_ready)
    );

endmodule

// Generic first-word-fall-through FIFO with wrap-bit pointers.
// Latency: a written entry is visible on rd_vld/rd_dat the cycle after the write.
// Backpressure: full is registered-pointer based; writes while full and reads while empty are ignored.
module cr_su_ib_rx_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         full,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         wr_en, rd_en;

    // Same index with opposite wrap bits means the writer has lapped the reader.
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_vld = (wr_ptr != rd_ptr);
    assign rd_dat = mem[rd_ptr[AW-1:0]];
    assign wr_en  = wr_vld && !full;
    assign rd_en  = rd_rdy && rd_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

endmodule

// File: tb/tb_cr_su_ib_rx.sv
// Directed bench for cr_su_ib_rx; a second instance with 2-bit counters exercises saturation.
module tb_cr_su_ib_rx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         su_ib_tvalid = 1'b0;
    logic         su_ib_tlast = 1'b0;
    logic [63:0]  su_ib_tdata = '0;
    logic         su_ib_tready;
    logic         rec_valid;
    logic [127:0] rec_data;
    logic         rec_ready = 1'b0;
    logic         frame_err_stb;
    logic [15:0]  rec_cnt, err_cnt;

    logic         sat_tready, sat_rec_valid, sat_err_stb;
    logic [127:0] sat_rec_data;
    logic [1:0]   sat_rec_cnt, sat_err_cnt;

    int           total = 0;
    int           bad = 0;
    int           pulses = 0;
    logic [127:0] got[$];

    cr_su_ib_rx #(.REC_BEATS(2), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .su_ib_tvalid(su_ib_tvalid), .su_ib_tlast(su_ib_tlast), .su_ib_tdata(su_ib_tdata),
        .su_ib_tready(su_ib_tready),
        .rec_valid(rec_valid), .rec_data(rec_data), .rec_ready(rec_ready),
        .frame_err_stb(frame_err_stb), .rec_cnt(rec_cnt), .err_cnt(err_cnt)
    );

    cr_su_ib_rx #(.REC_BEATS(2), .FIFO_DEPTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .su_ib_tvalid(su_ib_tvalid), .su_ib_tlast(su_ib_tlast), .su_ib_tdata(su_ib_tdata),
        .su_ib_tready(sat_tready),
        .rec_valid(sat_rec_valid), .rec_data(sat_rec_data), .rec_ready(rec_ready),
        .frame_err_stb(sat_err_stb), .rec_cnt(sat_rec_cnt), .err_cnt(sat_err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rec_valid && rec_ready) got.push_back(rec_data);
        if (frame_err_stb) pulses++;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    function automatic logic [63:0] bv(input int f, input int k);
        logic [7:0] ff, kk;
        ff = f[7:0];
        kk = k[7:0];
        return {ff, kk, 48'h5A5A_1234_C3C3};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l);
        int n;
        n = 0;
        su_ib_tvalid = 1'b1;
        su_ib_tdata  = d;
        su_ib_tlast  = l;
        #1;
        while (!su_ib_tready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!su_ib_tready) begin
            total++; bad++;
            $display("FAIL beat_accept_timeout data=%h", d);
        end
        @(posedge clk);
        #1;
        su_ib_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        su_ib_tvalid = 1'b0;
        rec_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int base, input int want);
        int n;
        n = 0;
        rec_ready = 1'b1;
        while ((got.size() - base) < want && n < 100) begin
            step();
            n++;
        end
        rec_ready = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        total++; if (su_ib_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b exp=0", su_ib_tready); end
        total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL rst_rec_valid got=%b exp=0", rec_valid); end
        total++; if (frame_err_stb !== 1'b0) begin bad++; $display("FAIL rst_err_stb got=%b exp=0", frame_err_stb); end
        total++; if (rec_cnt !== 16'd0 || err_cnt !== 16'd0) begin bad++; $display("FAIL rst_counters got=%h/%h exp=0/0", rec_cnt, err_cnt); end
        rst_n = 1'b1;
        #1;
        total++; if (su_ib_tready !== 1'b1) begin bad++; $display("FAIL rst_release_tready got=%b exp=1", su_ib_tready); end
    endtask

    task automatic test_basic();
        int base, p0;
        do_reset();
        rec_ready = 1'b1;
        base = got.size();
        p0 = pulses;
        send_beat(64'hA0A0_0000_1111_0000, 1'b0);
        su_ib_tdata = 64'hDEAD_DEAD_DEAD_DEAD;
        su_ib_tlast = 1'b1;
        repeat (3) step();
        send_beat(64'hA1A1_0000_2222_0001, 1'b1);
        total++; if (rec_valid !== 1'b1) begin bad++; $display("FAIL basic_a_valid got=%b exp=1", rec_valid); end
        total++; if (rec_data !== {64'hA1A1_0000_2222_0001, 64'hA0A0_0000_1111_0000}) begin bad++; $display("FAIL basic_a_data got=%h", rec_data); end
        send_beat(64'hB0B0_0000_3333_0000, 1'b0);
        send_beat(64'hB1B1_0000_4444_0001, 1'b1);
        total++; if (rec_data !== {64'hB1B1_0000_4444_0001, 64'hB0B0_0000_3333_0000} || rec_valid !== 1'b1) begin bad++; $display("FAIL basic_b_data got=%h", rec_data); end
        step();
        step();
        total++; if ((got.size() - base) != 2) begin bad++; $display("FAIL basic_count got=%0d exp=2", got.size() - base); end
        else begin
            total++; if (got[base] !== {64'hA1A1_0000_2222_0001, 64'hA0A0_0000_1111_0000}) begin bad++; $display("FAIL basic_order0 got=%h", got[base]); end
        end
        total++; if (rec_cnt !== 16'd2 || err_cnt !== 16'd0) begin bad++; $display("FAIL basic_cnts got=%0d/%0d exp=2/0", rec_cnt, err_cnt); end
        total++; if (pulses != p0) begin bad++; $display("FAIL basic_no_err_stb got=%0d exp=0", pulses - p0); end
    endtask

    task automatic test_backpressure();
        int base, nready;
        do_reset();
        base = got.size();
        for (int f = 1; f <= 4; f++) begin
            send_beat(bv(f, 0), 1'b0);
            send_beat(bv(f, 1), 1'b1);
        end
        total++; if (rec_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", rec_valid); end
        send_beat(bv(5, 0), 1'b0);
        su_ib_tvalid = 1'b1;
        su_ib_tdata  = bv(5, 1);
        su_ib_tlast  = 1'b1;
        nready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (su_ib_tready) nready++;
            step();
        end
        total++; if (nready != 0) begin bad++; $display("FAIL bp_full_stall got=%0d ready cycles exp=0", nready); end
        rec_ready = 1'b1;
        #1;
        total++; if (su_ib_tready !== 1'b0) begin bad++; $display("FAIL bp_same_cycle_pop got=%b exp=0", su_ib_tready); end
        step();
        rec_ready = 1'b0;
        total++; if (su_ib_tready !== 1'b1) begin bad++; $display("FAIL bp_after_pop got=%b exp=1", su_ib_tready); end
        step();
        su_ib_tvalid = 1'b0;
        drain(base, 5);
        total++; if ((got.size() - base) != 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", got.size() - base); end
        else begin
            for (int f = 1; f <= 5; f++) begin
                total++;
                if (got[base + f - 1] !== {bv(f, 1), bv(f, 0)}) begin
                    bad++; $display("FAIL bp_order%0d got=%h exp=%h", f, got[base + f - 1], {bv(f, 1), bv(f, 0)});
                end
            end
        end
        total++; if (rec_cnt !== 16'd5) begin bad++; $display("FAIL bp_rec_cnt got=%0d exp=5", rec_cnt); end
    endtask

    task automatic test_short();
        int base, p0;
        do_reset();
        rec_ready = 1'b1;
        base = got.size();
        p0 = pulses;
        send_beat(64'h5151_5151_5151_5151, 1'b1);
        total++; if (frame_err_stb !== 1'b1 || err_cnt !== 16'd1) begin bad++; $display("FAIL short_err got stb=%b cnt=%0d exp 1/1", frame_err_stb, err_cnt); end
        step();
        total++; if (frame_err_stb !== 1'b0) begin bad++; $display("FAIL short_stb_width got=%b exp=0", frame_err_stb); end
        send_beat(64'h6060_0000_0000_0060, 1'b0);
        send_beat(64'h6161_0000_0000_0061, 1'b1);
        step();
        step();
        total++; if ((got.size() - base) != 1) begin bad++; $display("FAIL short_count got=%0d exp=1", got.size() - base); end
        else begin
            total++; if (got[base] !== {64'h6161_0000_0000_0061, 64'h6060_0000_0000_0060}) begin bad++; $display("FAIL short_data got=%h", got[base]); end
        end
        total++; if (pulses - p0 != 1 || err_cnt !== 16'd1 || rec_cnt !== 16'd1) begin bad++; $display("FAIL short_totals got pulses=%0d err=%0d rec=%0d exp 1/1/1", pulses - p0, err_cnt, rec_cnt); end
    endtask

    task automatic test_long();
        int base, p0;
        do_reset();
        rec_ready = 1'b1;
        base = got.size();
        p0 = pulses;
        send_beat(64'h7070_7070_7070_7000, 1'b0);
        send_beat(64'h7070_7070_7070_7001, 1'b0);
        total++; if (frame_err_stb !== 1'b1 || err_cnt !== 16'd1) begin bad++; $display("FAIL long_err got stb=%b cnt=%0d exp 1/1", frame_err_stb, err_cnt); end
        send_beat(64'h7070_7070_7070_7002, 1'b0);
        send_beat(64'h7070_7070_7070_7003, 1'b0);
        send_beat(64'h7070_7070_7070_7004, 1'b1);
        step();
        total++; if (rec_valid !== 1'b0 || err_cnt !== 16'd1 || pulses - p0 != 1) begin bad++; $display("FAIL long_drop got valid=%b err=%0d pulses=%0d exp 0/1/1", rec_valid, err_cnt, pulses - p0); end
        send_beat(64'h8080_0000_0000_0080, 1'b0);
        send_beat(64'h8181_0000_0000_0081, 1'b1);
        step();
        step();
        total++; if ((got.size() - base) != 1) begin bad++; $display("FAIL long_count got=%0d exp=1", got.size() - base); end
        else begin
            total++; if (got[base] !== {64'h8181_0000_0000_0081, 64'h8080_0000_0000_0080}) begin bad++; $display("FAIL long_next_data got=%h", got[base]); end
        end
        total++; if (rec_cnt !== 16'd1) begin bad++; $display("FAIL long_rec_cnt got=%0d exp=1", rec_cnt); end
    endtask

    task automatic test_reset_mid();
        int base, p0;
        do_reset();
        send_beat(64'h9090_9090_9090_9090, 1'b0);
        rst_n = 1'b0;
        su_ib_tvalid = 1'b1;
        su_ib_tdata  = 64'h9191_9191_9191_9191;
        su_ib_tlast  = 1'b1;
        #1;
        total++; if (su_ib_tready !== 1'b0) begin bad++; $display("FAIL midrst_tready got=%b exp=0", su_ib_tready); end
        step();
        step();
        su_ib_tvalid = 1'b0;
        total++; if (rec_cnt !== 16'd0 || err_cnt !== 16'd0 || rec_valid !== 1'b0) begin bad++; $display("FAIL midrst_state got rec=%0d err=%0d valid=%b", rec_cnt, err_cnt, rec_valid); end
        rst_n = 1'b1;
        rec_ready = 1'b1;
        base = got.size();
        p0 = pulses;
        send_beat(64'hC0C0_0000_0000_00C0, 1'b0);
        send_beat(64'hC1C1_0000_0000_00C1, 1'b1);
        step();
        step();
        total++; if ((got.size() - base) != 1) begin bad++; $display("FAIL midrst_count got=%0d exp=1", got.size() - base); end
        else begin
            total++; if (got[base] !== {64'hC1C1_0000_0000_00C1, 64'hC0C0_0000_0000_00C0}) begin bad++; $display("FAIL midrst_data got=%h", got[base]); end
        end
        total++; if (err_cnt !== 16'd0 || pulses != p0) begin bad++; $display("FAIL midrst_no_err got err=%0d pulses=%0d exp 0/0", err_cnt, pulses - p0); end
    endtask

    task automatic test_push_pop();
        int base;
        logic [127:0] exp_q[$];
        do_reset();
        base = got.size();
        for (int f = 11; f <= 13; f++) begin
            send_beat(bv(f, 0), 1'b0);
            send_beat(bv(f, 1), 1'b1);
            exp_q.push_back({bv(f, 1), bv(f, 0)});
        end
        send_beat(bv(14, 0), 1'b0);
        su_ib_tvalid = 1'b1;
        su_ib_tdata  = bv(14, 1);
        su_ib_tlast  = 1'b1;
        rec_ready    = 1'b1;
        #1;
        total++; if (su_ib_tready !== 1'b1) begin bad++; $display("FAIL pp_ready_at3 got=%b exp=1", su_ib_tready); end
        step();
        su_ib_tvalid = 1'b0;
        rec_ready    = 1'b0;
        exp_q.push_back({bv(14, 1), bv(14, 0)});
        send_beat(bv(15, 0), 1'b0);
        send_beat(bv(15, 1), 1'b1);
        exp_q.push_back({bv(15, 1), bv(15, 0)});
        send_beat(bv(16, 0), 1'b0);
        su_ib_tvalid = 1'b1;
        su_ib_tdata  = bv(16, 1);
        su_ib_tlast  = 1'b1;
        #1;
        total++; if (su_ib_tready !== 1'b0) begin bad++; $display("FAIL pp_full_after got=%b exp=0", su_ib_tready); end
        step();
        su_ib_tvalid = 1'b0;
        drain(base, 5);
        total++; if ((got.size() - base) != 5) begin bad++; $display("FAIL pp_count got=%0d exp=5", got.size() - base); end
        else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (got[base + i] !== exp_q[i]) begin bad++; $display("FAIL pp_order%0d got=%h exp=%h", i, got[base + i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        rec_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_beat(bv(20 + f, 0), 1'b0);
            send_beat(bv(20 + f, 1), 1'b1);
        end
        total++; if (sat_rec_cnt !== 2'd3 || rec_cnt !== 16'd3) begin bad++; $display("FAIL sat_at_max got=%0d/%0d exp=3/3", sat_rec_cnt, rec_cnt); end
        for (int f = 0; f < 2; f++) begin
            send_beat(bv(30 + f, 0), 1'b0);
            send_beat(bv(30 + f, 1), 1'b1);
        end
        total++; if (sat_rec_cnt !== 2'd3 || rec_cnt !== 16'd5) begin bad++; $display("FAIL sat_rec_hold got=%0d/%0d exp=3/5", sat_rec_cnt, rec_cnt); end
        for (int f = 0; f < 4; f++) begin
            send_beat(bv(40 + f, 0), 1'b1);
        end
        total++; if (sat_err_cnt !== 2'd3 || err_cnt !== 16'd4) begin bad++; $display("FAIL sat_err_hold got=%0d/%0d exp=3/4", sat_err_cnt, err_cnt); end
        rec_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_short();
        test_long();
        test_reset_mid();
        test_push_pop();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
